// File: rtl/fir_decim_fifo.sv
// fir_decim_fifo
//   Takes the FIR filter output stream and discards the start-up transient.
//   It then keeps one sample out of every DECIM valid samples and buffers the
//   kept samples in a first-word-fall-through FIFO for a consumer that may stall.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous, active-high reset
//   in_data    : signed FIR output sample
//   in_valid   : in_data valid this cycle (no upstream backpressure)
//   out_data   : signed FIFO head sample, 0 when the FIFO is empty
//   out_valid  : FIFO non-empty
//   out_ready  : consumer accepts out_data this cycle
//   level      : FIFO occupancy, 0..DEPTH
//   overflow   : sticky, set when a kept sample found the FIFO full
//   clear_ovf  : one-cycle pulse clearing overflow (a simultaneous drop wins)
module fir_decim_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DECIM      = 4,
  parameter int DEPTH      = 8,
  parameter int WARMUP     = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [DATA_WIDTH-1:0]  in_data,
  input  logic                          in_valid,
  output logic signed [DATA_WIDTH-1:0]  out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(DEPTH+1)-1:0]    level,
  output logic                          overflow,
  input  logic                          clear_ovf
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
  localparam int PW = (DECIM < 2) ? 1 : $clog2(DECIM);

  logic [WW-1:0] warm_q, warm_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic warm_done;
  logic keep;
  logic pop;
  logic full;
  logic wr_en;
  logic drop;

  always_comb begin
    warm_done = (warm_q == WW'(WARMUP));
    keep      = in_valid && warm_done && (phase_q == '0);
    pop       = (level_q != '0) && out_ready;
    full      = (level_q == LW'(DEPTH));
    // A pop in the same cycle frees the slot the new sample goes into.
    wr_en     = keep && (!full || pop);
    drop      = keep && full && !pop;

    warm_d   = warm_q;
    phase_d  = phase_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    // Warm-up count stops at WARMUP, so it also acts as the "done" flag.
    if (in_valid && !warm_done) begin
      warm_d = warm_q + WW'(1);
    end
    if (in_valid && warm_done) begin
      phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
    end

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (wr_en && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !wr_en) begin
      level_d = level_q - LW'(1);
    end

    // Set has priority over clear.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      warm_q   <= '0;
      phase_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      warm_q   <= warm_d;
      phase_q  <= phase_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage has no reset; the pointers and level alone define what is valid.
  // The write is gated by reset so a flushed FIFO never holds a sample
  // written in the reset cycle.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  // Head is read combinationally so out_data shows the head entry in the
  // same cycle out_valid rises.
  always_comb begin
    out_valid = (level_q != '0);
    out_data  = out_valid ? $signed(mem[rd_ptr_q]) : '0;
    level     = level_q;
    overflow  = ovf_q;
  end

endmodule
